// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a 2-of-3 majority vote per bit,
// optional odd/even parity, 1 or 2 stop bits, break handling and a
// valid/ready output holding register with overrun detection.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = $clog2(BPS_CNT) + 1;

  localparam logic [CNT_W-1:0] SMP0     = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] SMP1     = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] SMP2     = CNT_W'(BPS_CNT / 2 + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic             ODD_REF   = (PARITY == 1);
  localparam logic             PAR_EN    = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rxd_s1, rxd_s2, rxd_s3;
  logic [1:0]           warm_cnt;
  logic [CNT_W-1:0]     clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 smp_a, smp_b;
  logic                 par_bad;
  logic                 stop_bad;

  logic fall_edge, maj, at_mid, at_wrap, done, frame_bad;

  // Edges are ignored until the synchroniser holds three real line samples,
  // so a line already low when reset is released cannot fake a start bit.
  assign fall_edge = rxd_s3 & ~rxd_s2 & (warm_cnt == 2'd3);
  assign maj       = (smp_a & smp_b) | (smp_a & rxd_s2) | (smp_b & rxd_s2);
  assign at_mid    = (clk_cnt == SMP2);
  assign at_wrap   = (clk_cnt == BIT_LAST);
  assign done      = (state == ST_STOP) && at_mid && (bit_cnt == LAST_STOP);
  assign frame_bad = stop_bad | ~maj;
  assign rx_busy   = (state != ST_IDLE);

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_s3   <= 1'b1;
      warm_cnt <= 2'd0;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // Receive FSM: bit timing, majority sampling, shifting and error capture.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= 4'd0;
      shift_reg <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      if (state == ST_START || state == ST_DATA ||
          state == ST_PARITY || state == ST_STOP) begin
        clk_cnt <= at_wrap ? '0 : clk_cnt + CNT_W'(1);
        if (clk_cnt == SMP0) smp_a <= rxd_s2;
        if (clk_cnt == SMP1) smp_b <= rxd_s2;
      end
      case (state)
        ST_IDLE: begin
          clk_cnt  <= '0;
          bit_cnt  <= 4'd0;
          par_bad  <= 1'b0;
          stop_bad <= 1'b0;
          if (fall_edge) state <= ST_START;
        end
        ST_START: begin
          if (at_mid && maj) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
          end else if (at_wrap) begin
            state   <= ST_DATA;
            bit_cnt <= 4'd0;
          end
        end
        ST_DATA: begin
          if (at_mid) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= 4'd0;
              state   <= (PARITY == 0) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (at_mid) par_bad <= ((^shift_reg) ^ maj) != ODD_REF;
          if (at_wrap) begin
            state   <= ST_STOP;
            bit_cnt <= 4'd0;
          end
        end
        ST_STOP: begin
          if (done) begin
            state   <= frame_bad ? ST_WAIT_IDLE : ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= 4'd0;
          end else begin
            if (at_mid) stop_bad <= stop_bad | ~maj;
            if (at_wrap) bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register: load on completion unless a word is still held.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data    <= shift_reg;
          parity_err <= PAR_EN & par_bad;
          frame_err  <= frame_bad;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg with an 8N1 and an 8E1
// instance at BPS_CNT=10; accepted words are checked against a scoreboard.
module tb_uart_rx_cfg;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic rxd_n, rxd_e;
  logic rdy_n, rdy_e;

  logic [7:0] data_n, data_e;
  logic valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
  logic ovr_n_sig, ovr_e_sig, busy_n, busy_e;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_n[$];
  exp_t q_e[$];

  int n_cmp = 0;
  int n_err = 0;
  int ovr_n = 0;
  int ovr_e = 0;
  int o0;

  // 50 MHz clock
  always #10 sys_clk = ~sys_clk;

  uart_rx_cfg #(
    .CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) dut_n (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_n),
    .rx_data(data_n), .rx_valid(valid_n), .rx_ready(rdy_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n_sig),
    .rx_busy(busy_n)
  );

  uart_rx_cfg #(
    .CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) dut_e (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_e),
    .rx_data(data_e), .rx_valid(valid_e), .rx_ready(rdy_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e_sig),
    .rx_busy(busy_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drive one frame, LSB first, 10 clocks per bit; optional one-cycle spike.
  task automatic send_frame(input int sel, input logic [15:0] bits, input int n, input int spike);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 10; c++) begin
        logic v;
        v = bits[i];
        if (i == spike && c == 6) v = ~v;
        if (sel == 0) rxd_n = v;
        else          rxd_e = v;
        @(posedge sys_clk);
        #1;
      end
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8e1(input logic [7:0] d, input logic pb, input logic stop);
    return {5'b0, stop, pb, d, 1'b0};
  endfunction

  task automatic push_n(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q_n.push_back(e);
  endtask

  task automatic push_e(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q_e.push_back(e);
  endtask

  // Scoreboard monitor for the 8N1 instance: compare each accepted word.
  always @(negedge sys_clk) begin
    exp_t e;
    if (ovr_n_sig) ovr_n++;
    if (valid_n && rdy_n) begin
      if (q_n.size() == 0) begin
        chk("n_spurious_valid", 32'(valid_n), 32'd0);
      end else begin
        e = q_n.pop_front();
        $display("8N1 word data=0x%02h perr=%0d ferr=%0d", data_n, perr_n, ferr_n);
        chk("n_data", 32'(data_n), 32'(e.d));
        chk("n_perr", 32'(perr_n), 32'(e.pe));
        chk("n_ferr", 32'(ferr_n), 32'(e.fe));
      end
    end
  end

  // Scoreboard monitor for the 8E1 instance.
  always @(negedge sys_clk) begin
    exp_t e;
    if (ovr_e_sig) ovr_e++;
    if (valid_e && rdy_e) begin
      if (q_e.size() == 0) begin
        chk("e_spurious_valid", 32'(valid_e), 32'd0);
      end else begin
        e = q_e.pop_front();
        $display("8E1 word data=0x%02h perr=%0d ferr=%0d", data_e, perr_e, ferr_e);
        chk("e_data", 32'(data_e), 32'(e.d));
        chk("e_perr", 32'(perr_e), 32'(e.pe));
        chk("e_ferr", 32'(ferr_e), 32'(e.fe));
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    rxd_n = 1'b1; rxd_e = 1'b1;
    rdy_n = 1'b1; rdy_e = 1'b1;
    idle(3);
    chk("rst_valid", 32'(valid_n), 32'd0);
    chk("rst_data",  32'(data_n),  32'd0);
    chk("rst_busy",  32'(busy_n),  32'd0);
    chk("rst_perr",  32'(perr_n),  32'd0);
    chk("rst_ferr",  32'(ferr_n),  32'd0);
    chk("rst_ovr",   32'(ovr_n_sig), 32'd0);
    sys_rst_n = 1'b1;
    idle(10);

    // Clean 8N1 frame
    push_n(8'hA5, 1'b0, 1'b0);
    send_frame(0, f8n1(8'hA5, 1'b1), 10, -1);
    idle(5);
    chk("a5_no_ovr", 32'(ovr_n), 32'd0);

    // Short low glitch is a false start
    rxd_n = 1'b0;
    idle(3);
    rxd_n = 1'b1;
    idle(10);
    chk("glitch_busy", 32'(busy_n), 32'd0);

    // One-cycle spike on data bit 2 is outvoted
    push_n(8'h55, 1'b0, 1'b0);
    send_frame(0, f8n1(8'h55, 1'b1), 10, 3);
    idle(5);

    // 8E1: wrong then right parity bit for 0x07
    push_e(8'h07, 1'b1, 1'b0);
    send_frame(1, f8e1(8'h07, 1'b0, 1'b1), 11, -1);
    idle(5);
    push_e(8'h07, 1'b0, 1'b0);
    send_frame(1, f8e1(8'h07, 1'b1, 1'b1), 11, -1);
    idle(5);

    // Break: stop bit low, line stays low
    push_n(8'h3C, 1'b0, 1'b1);
    send_frame(0, f8n1(8'h3C, 1'b0), 10, -1);
    idle(40);
    chk("break_busy_low", 32'(busy_n), 32'd1);
    rxd_n = 1'b1;
    idle(6);
    chk("break_busy_released", 32'(busy_n), 32'd0);

    // Reset with the line already low must not start a frame
    sys_rst_n = 1'b0;
    rxd_n = 1'b0;
    idle(3);
    sys_rst_n = 1'b1;
    idle(30);
    chk("rstlow_busy",  32'(busy_n),  32'd0);
    chk("rstlow_valid", 32'(valid_n), 32'd0);
    rxd_n = 1'b1;
    idle(10);

    // Overrun: second word dropped while first is held
    rdy_n = 1'b0;
    push_n(8'h11, 1'b0, 1'b0);
    send_frame(0, f8n1(8'h11, 1'b1), 10, -1);
    idle(5);
    o0 = ovr_n;
    send_frame(0, f8n1(8'h22, 1'b1), 10, -1);
    idle(5);
    chk("ovr_pulse_count", 32'(ovr_n - o0), 32'd1);
    chk("ovr_hold_data",   32'(data_n),     32'h11);
    chk("ovr_hold_valid",  32'(valid_n),    32'd1);

    // Handshake in the completion cycle: new word loads, no overrun
    o0 = ovr_n;
    push_n(8'h22, 1'b0, 1'b0);
    fork
      send_frame(0, f8n1(8'h22, 1'b1), 10, -1);
      begin
        repeat (99) @(posedge sys_clk);
        #1 rdy_n = 1'b1;
      end
    join
    idle(5);
    chk("hs_no_ovr", 32'(ovr_n - o0), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF
    fork
      send_frame(0, f8n1(8'hFF, 1'b1), 10, -1);
      begin
        repeat (55) @(posedge sys_clk);
        chk("pre_rst_busy", 32'(busy_n), 32'd1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_n),   32'd0);
        chk("midrst_data",  32'(data_n),    32'd0);
        chk("midrst_perr",  32'(perr_n),    32'd0);
        chk("midrst_ferr",  32'(ferr_n),    32'd0);
        chk("midrst_ovr",   32'(ovr_n_sig), 32'd0);
        chk("midrst_busy",  32'(busy_n),    32'd0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
      end
    join
    idle(10);
    push_n(8'h5A, 1'b0, 1'b0);
    send_frame(0, f8n1(8'h5A, 1'b1), 10, -1);
    idle(10);

    chk("n_queue_empty", 32'(q_n.size()), 32'd0);
    chk("e_queue_empty", 32'(q_e.size()), 32'd0);
    chk("e_no_ovr",      32'(ovr_e),      32'd0);
    chk("e_idle",        32'(busy_e),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
